// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with whole-scan debounce; one kbEN strobe per accepted press.
// Accept is registered on the edge that takes column 3's last sample; kbEN is a strobe, there is no backpressure.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] pressedkey,
  output logic       kbEN
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DS       = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx;
  logic [3:0]    sync1, sync2;
  logic [3:0]    slot0, slot1, slot2;
  logic          slot_end, scan_end;
  logic [15:0]   hits;
  logic [4:0]    hit_cnt;
  logic [3:0]    hit_pos;
  logic          single, none;
  logic [3:0]    code;
  state_t        state, state_nxt;
  logic [3:0]    cand, cand_nxt;
  logic [CW-1:0] match_cnt, match_nxt, rel_cnt, rel_nxt;
  logic          accept;

  function automatic logic [3:0] key_code(input logic [3:0] pos);
    case (pos)
      4'd0:  key_code = 4'h1;
      4'd1:  key_code = 4'h2;
      4'd2:  key_code = 4'h3;
      4'd3:  key_code = 4'hC;
      4'd4:  key_code = 4'h4;
      4'd5:  key_code = 4'h5;
      4'd6:  key_code = 4'h6;
      4'd7:  key_code = 4'hD;
      4'd8:  key_code = 4'h7;
      4'd9:  key_code = 4'h8;
      4'd10: key_code = 4'h9;
      4'd11: key_code = 4'hE;
      4'd12: key_code = 4'hB;
      4'd13: key_code = 4'h0;
      4'd14: key_code = 4'hA;
      default: key_code = 4'hF;
    endcase
  endfunction

  assign slot_end = (div_cnt == DIV_LAST);
  assign scan_end = slot_end && (col_idx == 2'd3);
  assign cols     = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      col_idx <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
      slot0 <= '0;
      slot1 <= '0;
      slot2 <= '0;
    end else begin
      sync1 <= rows;
      sync2 <= sync1;
      if (slot_end) begin
        case (col_idx)
          2'd0:    slot0 <= ~sync2;
          2'd1:    slot1 <= ~sync2;
          2'd2:    slot2 <= ~sync2;
          default: ;
        endcase
      end
    end
  end

  // Column 3 is judged straight from the synchroniser so the decision lands on its sample edge.
  always_comb begin
    hits = '0;
    for (int r = 0; r < 4; r++) begin
      hits[r*4 + 0] = slot0[r];
      hits[r*4 + 1] = slot1[r];
      hits[r*4 + 2] = slot2[r];
      hits[r*4 + 3] = ~sync2[r];
    end
  end

  always_comb begin
    hit_cnt = '0;
    hit_pos = '0;
    for (int i = 0; i < 16; i++) begin
      if (hits[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_pos = 4'(i);
      end
    end
  end

  assign single = (hit_cnt == 5'd1);
  assign none   = (hit_cnt == 5'd0);
  assign code   = key_code(hit_pos);

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    match_nxt = match_cnt;
    rel_nxt   = rel_cnt;
    accept    = 1'b0;
    if (scan_end) begin
      unique case (state)
        IDLE: begin
          if (single) begin
            cand_nxt  = code;
            match_nxt = CW'(1);
            if (DEBOUNCE_SCANS == 1) accept = 1'b1;
            else state_nxt = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (single && (code == cand)) begin
            match_nxt = match_cnt + CW'(1);
            if ((match_cnt + CW'(1)) >= DS) accept = 1'b1;
          end else begin
            state_nxt = IDLE;
            match_nxt = '0;
          end
        end
        HELD: begin
          if (!none) begin
            rel_nxt = '0;
          end else if ((rel_cnt + CW'(1)) >= DS) begin
            state_nxt = IDLE;
            rel_nxt   = '0;
            match_nxt = '0;
          end else begin
            rel_nxt = rel_cnt + CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (accept) begin
        state_nxt = HELD;
        rel_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cand       <= '0;
      match_cnt  <= '0;
      rel_cnt    <= '0;
      pressedkey <= 4'h0;
      kbEN       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      match_cnt <= match_nxt;
      rel_cnt   <= rel_nxt;
      kbEN      <= accept;
      if (accept) pressedkey <= cand_nxt;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus random key patterns against a scan-level reference model.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DS = 3;
  localparam int P  = 4 * SD;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rows, cols, pressedkey;
  logic        kbEN;
  logic [15:0] mask = '0;

  int n_checks = 0;
  int n_errors = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst_n(rst_n), .rows(rows), .cols(cols),
    .pressedkey(pressedkey), .kbEN(kbEN)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to the column being driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4 + c] && !cols[c]) rows[r] = 1'b0;
  end

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hC,
                              4'h4, 4'h5, 4'h6, 4'hD,
                              4'h7, 4'h8, 4'h9, 4'hE,
                              4'hB, 4'h0, 4'hA, 4'hF};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: edge k since reset, key mask history, and runs of identical scan results.
  int          k = 0;
  logic [15:0] hist [P];
  logic [15:0] m_s;
  int          m_hits, m_pos;
  int          run_len = 0, quiet = 0;
  logic [3:0]  run_key = '0;
  logic        held = 1'b0;
  logic [3:0]  exp_key = 4'h0, exp_cols = 4'hE;
  logic        exp_kben = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0; run_len = 0; quiet = 0; held = 1'b0;
      exp_key = 4'h0; exp_kben = 1'b0;
    end else begin
      k++;
      hist[k % P] = mask;
      exp_kben = 1'b0;
      if (k % P == 0) begin
        m_hits = 0; m_pos = 0;
        for (int c = 0; c < 4; c++) begin
          m_s = hist[(k - 2 - (3 - c) * SD) % P];
          for (int r = 0; r < 4; r++)
            if (m_s[r*4 + c]) begin m_hits++; m_pos = r*4 + c; end
        end
        if (!held) begin
          if (m_hits == 1 && (run_len == 0 || keymap[m_pos] == run_key)) begin
            if (run_len == 0) run_key = keymap[m_pos];
            run_len++;
          end else begin
            run_len = 0;
          end
          if (run_len == DS) begin
            exp_key = run_key; exp_kben = 1'b1;
            held = 1'b1; quiet = 0; run_len = 0;
          end
        end else begin
          if (m_hits == 0) quiet++; else quiet = 0;
          if (quiet == DS) begin held = 1'b0; quiet = 0; end
        end
      end
    end
    exp_cols = ~(4'b0001 << ((k / SD) % 4));
  end

  logic       prev_kben = 1'b0;
  int         pulses = 0;
  logic [3:0] last_code = '0;

  always @(negedge clk) begin
    chk("kbEN", {15'd0, kbEN}, {15'd0, exp_kben});
    chk("pressedkey", {12'd0, pressedkey}, {12'd0, exp_key});
    chk("cols", {12'd0, cols}, {12'd0, exp_cols});
    chk("kbEN_back_to_back", {15'd0, kbEN & prev_kben}, 16'd0);
    prev_kben = kbEN;
    if (kbEN) begin pulses++; last_code = pressedkey; end
  end

  task automatic hold(input logic [15:0] m, input int n);
    mask = m;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int          base;
    int          sel;
    int          dur;
    logic [15:0] m;

    repeat (2) @(negedge clk);
    chk("rst_cols", {12'd0, cols}, 16'h000E);
    chk("rst_key", {12'd0, pressedkey}, 16'h0000);
    chk("rst_kben", {15'd0, kbEN}, 16'h0000);
    #2 rst_n = 1'b1;

    base = pulses;
    hold(16'h0001, 300);
    #1 chk("clean_strobes", 16'(pulses - base), 16'd1);
    chk("clean_code", {12'd0, last_code}, 16'h0001);
    hold(16'h0000, 80);
    #1 chk("clean_after_release", {12'd0, pressedkey}, 16'h0001);
    chk("clean_strobes_after", 16'(pulses - base), 16'd1);

    for (int i = 0; i < 16; i++) begin
      base = pulses;
      hold(16'h0001 << i, 80);
      hold(16'h0000, 80);
      #1 chk("map_strobes", 16'(pulses - base), 16'd1);
      chk("map_code", {12'd0, last_code}, {12'd0, keymap[i]});
    end

    base = pulses;
    for (int j = 0; j < 16; j++) hold((j % 2 == 0) ? 16'h0020 : 16'h0000, 5);
    hold(16'h0020, 100);
    #1 chk("bounce_strobes", 16'(pulses - base), 16'd1);
    chk("bounce_code", {12'd0, last_code}, 16'h0005);
    hold(16'h0000, 80);

    base = pulses;
    hold(16'h0003, 200);
    #1 chk("ghost_strobes", 16'(pulses - base), 16'd0);
    hold(16'h0002, 80);
    #1 chk("ghost_single_strobes", 16'(pulses - base), 16'd1);
    chk("ghost_code", {12'd0, last_code}, 16'h0002);
    hold(16'h0000, 80);

    base = pulses;
    hold(16'h0800, 80);
    hold(16'h0000, 16);
    hold(16'h0800, 80);
    #1 chk("glitch_strobes", 16'(pulses - base), 16'd1);
    chk("glitch_code", {12'd0, last_code}, 16'h000E);
    hold(16'h0000, 80);
    hold(16'h0800, 80);
    #1 chk("repress_strobes", 16'(pulses - base), 16'd2);
    chk("repress_code", {12'd0, last_code}, 16'h000E);
    hold(16'h0000, 80);

    hold(16'h0004, 24);
    #2 rst_n = 1'b0;
    mask = 16'h0000;
    #1 chk("midrst_cols", {12'd0, cols}, 16'h000E);
    chk("midrst_key", {12'd0, pressedkey}, 16'h0000);
    chk("midrst_kben", {15'd0, kbEN}, 16'h0000);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    base = pulses;
    hold(16'h0000, 80);
    #1 chk("post_rst_strobes", 16'(pulses - base), 16'd0);
    hold(16'h2000, 80);
    #1 chk("post_rst_press", 16'(pulses - base), 16'd1);
    chk("post_rst_code", {12'd0, last_code}, 16'h0000);
    hold(16'h0000, 80);

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      dur = $urandom_range(5, 120);
      if (sel < 7)      m = 16'h0001 << $urandom_range(0, 15);
      else if (sel < 8) m = 16'h0000;
      else              m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      hold(m, dur);
    end
    hold(16'h0000, 80);

    #1 $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
